// File: rtl/rsa_loader.sv
// rsa_loader: operand entry stage feeding the rsa core.
//   Synchronises and debounces a push-button and a switch bus, then issues
//   one ldr_load strobe with a stable ldr_dout byte per accepted press.
//   After NUM_OPS operands it locks out entry until ldr_core_done.
//   Latency: DEB_CNT+2 clock edges from a clean button rise to ldr_load.
//   Backpressure: none on the button. Presses arriving while busy are dropped.
//
// Ports:
//   ldr_clk        clock, rising edge
//   ldr_rst        synchronous reset, active-high
//   ldr_btn        raw asynchronous push-button, active-high
//   ldr_sw         raw asynchronous switch bus
//   ldr_core_done  core finished the current operation (level or pulse)
//   ldr_load       single-cycle load strobe to the core
//   ldr_dout       operand byte, held between loads
//   ldr_idx        index of the next operand to capture
//   ldr_busy       all operands sent, waiting for ldr_core_done
//   ldr_err        last press rejected because the operand was zero
//
// Optional feature, enabled by defining LDR_ZERO_CHK_EN:
//   zero operands are rejected in COLLECT and flagged on ldr_err.
//   Without the macro, zero bytes load normally and ldr_err is tied low.

module rsa_loader #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEB_CNT    = 16,
  parameter  int NUM_OPS    = 4,
  localparam int IDX_W      = $clog2(NUM_OPS)
) (
  input  logic                  ldr_clk,
  input  logic                  ldr_rst,
  input  logic                  ldr_btn,
  input  logic [DATA_WIDTH-1:0] ldr_sw,
  input  logic                  ldr_core_done,
  output logic                  ldr_load,
  output logic [DATA_WIDTH-1:0] ldr_dout,
  output logic [IDX_W-1:0]      ldr_idx,
  output logic                  ldr_busy,
  output logic                  ldr_err
);

  localparam int CNT_W = $clog2(DEB_CNT);

  typedef enum logic [0:0] {
    COLLECT   = 1'b0,
    WAIT_DONE = 1'b1
  } state_t;

  // Two-flop synchronisers for the button and the switches.
  logic                  btn_s1;
  logic                  btn_s2;
  logic [DATA_WIDTH-1:0] sw_s1;
  logic [DATA_WIDTH-1:0] sw_s2;

  // Debouncer state.
  logic [CNT_W-1:0] cnt;
  logic             stb;
  logic             stb_q;
  logic             press;

  state_t state;

  always_ff @(posedge ldr_clk) begin
    if (ldr_rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= ldr_btn;
      btn_s2 <= btn_s1;
      sw_s1  <= ldr_sw;
      sw_s2  <= sw_s1;
    end
  end

  // The debounced level starts high so that a button held through reset
  // never looks like a press; entry arms only after a debounced release.
  // Any cycle where the synchronised level agrees with stb restarts the count.
  always_ff @(posedge ldr_clk) begin
    if (ldr_rst) begin
      cnt   <= '0;
      stb   <= 1'b1;
      stb_q <= 1'b1;
    end else begin
      stb_q <= stb;
      if (btn_s2 == stb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CNT - 1)) begin
        stb <= btn_s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Only the debounced rising edge counts as a press.
  assign press = stb & ~stb_q;

`ifdef LDR_ZERO_CHK_EN
  logic err_q;
  assign ldr_err = err_q;
`else
  assign ldr_err = 1'b0;
`endif

  always_ff @(posedge ldr_clk) begin
    if (ldr_rst) begin
      state    <= COLLECT;
      ldr_load <= 1'b0;
      ldr_dout <= '0;
      ldr_idx  <= '0;
      ldr_busy <= 1'b0;
`ifdef LDR_ZERO_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      ldr_load <= 1'b0;
      case (state)
        COLLECT: begin
          // ldr_core_done is deliberately ignored here.
          if (press) begin
`ifdef LDR_ZERO_CHK_EN
            if (sw_s2 == '0) begin
              err_q <= 1'b1;
            end else begin
              err_q    <= 1'b0;
`endif
              ldr_load <= 1'b1;
              ldr_dout <= sw_s2;
              if (ldr_idx == IDX_W'(NUM_OPS - 1)) begin
                // Last operand: wrap and report busy on the same edge.
                ldr_idx  <= '0;
                ldr_busy <= 1'b1;
                state    <= WAIT_DONE;
              end else begin
                ldr_idx <= ldr_idx + IDX_W'(1);
              end
`ifdef LDR_ZERO_CHK_EN
            end
`endif
          end
        end
        WAIT_DONE: begin
          // Presses are dropped here; when one coincides with done,
          // done wins and the press is not replayed later.
          if (ldr_core_done) begin
            ldr_busy <= 1'b0;
            state    <= COLLECT;
          end
        end
        default: begin
          state    <= COLLECT;
          ldr_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_loader.sv
module tb_rsa_loader;

  localparam int DW  = 8;
  localparam int DEB = 4;
  localparam int NOP = 4;
  // Negedge-counted latency from driving btn high to seeing ldr_load:
  // load is registered at edge DEB+2, which is the (DEB+3)-th posedge.
  localparam int LAT = DEB + 3;

  logic          clk;
  logic          rst;
  logic          btn;
  logic [DW-1:0] sw;
  logic          done;
  logic          load;
  logic [DW-1:0] dout;
  logic [1:0]    idx;
  logic          busy;
  logic          err;

  int n_chk;
  int n_err;
  int p_cnt;
  int p_lat;
  logic [DW-1:0] p_dout;

  rsa_loader #(
    .DATA_WIDTH(DW),
    .DEB_CNT   (DEB),
    .NUM_OPS   (NOP)
  ) dut (
    .ldr_clk      (clk),
    .ldr_rst      (rst),
    .ldr_btn      (btn),
    .ldr_sw       (sw),
    .ldr_core_done(done),
    .ldr_load     (load),
    .ldr_dout     (dout),
    .ldr_idx      (idx),
    .ldr_busy     (busy),
    .ldr_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(10);
  endtask

  // Drive one press with switch value v and release it again; optionally
  // pulse done for the cycle ending at posedge number done_k (0 = never).
  // Records pulse count, latency of the first pulse and ldr_dout at it.
  task automatic do_press(input logic [DW-1:0] v, input int done_k);
    p_cnt  = 0;
    p_lat  = 0;
    p_dout = '0;
    @(negedge clk);
    sw  = v;
    btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      done = (k == done_k);
      @(posedge clk);
      @(negedge clk);
      if (load) begin
        p_cnt++;
        if (p_lat == 0) begin
          p_lat  = k;
          p_dout = dout;
        end
      end
    end
    done = 1'b0;
    btn  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (load) p_cnt++;
    end
  endtask

  logic [7:0]    pat;
  logic [DW-1:0] ops [4];
  int            g_cnt;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    btn   = 1'b0;
    sw    = '0;
    done  = 1'b0;
    pat   = 8'b0011_0011;
    ops[0] = 8'h0B; ops[1] = 8'h0D; ops[2] = 8'h03; ops[3] = 8'h05;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_load", {31'd0, load}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_idx",  {30'd0, idx},  32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err",  {31'd0, err},  32'd0);
    rst = 1'b0;
    idle(10);

    // 1: single clean press
    do_press(8'h0B, 0);
    check("t1_pulses", p_cnt, 1);
    check("t1_lat",    p_lat, LAT);
    check("t1_dout",   {24'd0, p_dout}, 32'h0B);
    check("t1_idx",    {30'd0, idx}, 32'd1);

    // 2: bouncing button, then held high
    g_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      btn = pat[i];
      sw  = 8'h0D;
      @(posedge clk);
      @(negedge clk);
      if (load) g_cnt++;
    end
    check("t2_bounce_pulses", g_cnt, 0);
    do_press(8'h0D, 0);
    check("t2_pulses", p_cnt, 1);
    check("t2_lat",    p_lat, LAT);
    check("t2_dout",   {24'd0, dout}, 32'h0D);

    // 3: full operand sequence, lockout, release by done
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_press(ops[i], 0);
      check("t3_pulses", p_cnt, 1);
      check("t3_dout",   {24'd0, p_dout}, {24'd0, ops[i]});
      check("t3_busy",   {31'd0, busy}, (i == 3) ? 32'd1 : 32'd0);
    end
    check("t3_idx_wrap", {30'd0, idx}, 32'd0);
    do_press(8'h77, 0);
    check("t3_locked_pulses", p_cnt, 0);
    check("t3_locked_busy",   {31'd0, busy}, 32'd1);
    check("t3_locked_dout",   {24'd0, dout}, 32'h05);
    done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done = 1'b0;
    check("t3_done_busy", {31'd0, busy}, 32'd0);
    check("t3_done_idx",  {30'd0, idx},  32'd0);

    // 4: zero operand
    do_reset();
    do_press(8'h00, 0);
`ifdef LDR_ZERO_CHK_EN
    check("t4_zero_pulses", p_cnt, 0);
    check("t4_zero_err",    {31'd0, err}, 32'd1);
    check("t4_zero_idx",    {30'd0, idx}, 32'd0);
    do_press(8'h11, 0);
    check("t4_nz_pulses", p_cnt, 1);
    check("t4_nz_err",    {31'd0, err}, 32'd0);
    check("t4_nz_dout",   {24'd0, dout}, 32'h11);
`else
    check("t4_zero_pulses", p_cnt, 1);
    check("t4_zero_dout",   {24'd0, p_dout}, 32'd0);
    check("t4_zero_err",    {31'd0, err}, 32'd0);
    check("t4_zero_idx",    {30'd0, idx}, 32'd1);
`endif

    // 5: reset mid-sequence with button held
    do_reset();
    do_press(8'h21, 0);
    do_press(8'h22, 0);
    check("t5_pre_idx", {30'd0, idx}, 32'd2);
    btn = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_load", {31'd0, load}, 32'd0);
    check("t5_rst_dout", {24'd0, dout}, 32'd0);
    check("t5_rst_idx",  {30'd0, idx},  32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    g_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (load) g_cnt++;
    end
    check("t5_held_pulses", g_cnt, 0);
    btn = 1'b0;
    idle(10);
    do_press(8'h07, 0);
    check("t5_pulses", p_cnt, 1);
    check("t5_dout",   {24'd0, p_dout}, 32'h07);
    check("t5_idx",    {30'd0, idx}, 32'd1);

    // 6: press and done in the same cycle while waiting
    do_reset();
    for (int i = 0; i < 4; i++) do_press(ops[i], 0);
    check("t6_pre_busy", {31'd0, busy}, 32'd1);
    do_press(8'h44, LAT);
    check("t6_pulses", p_cnt, 0);
    check("t6_busy",   {31'd0, busy}, 32'd0);
    check("t6_idx",    {30'd0, idx},  32'd0);
    check("t6_dout",   {24'd0, dout}, 32'h05);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
